moore_seq_tx: RTL and testbench

Serial framed transmitter, the sending end of the one-bit sync-preamble link. It accepts a parallel word over a valid/ready handshake and shifts out a frame one bit per clock. Each frame is the preamble `001`, then the data word MSB first, then an optional parity bit. The serial output idles high, so a downstream `001` Moore detector sees the preamble only at frame start. All outputs are Moore outputs, decoded from registered state only.

---
 rtl/moore_seq_pkg.sv | 26 ++
 rtl/seq_tx_shreg.sv | 66 ++++++
 rtl/moore_seq_tx.sv | 176 +++++++++++++++++
 tb/tb_moore_seq_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// -----------------------------------------------------------------------------
// moore_seq_pkg
// Shared definitions for the one-bit sync-preamble link (transmitter and
// detector side).
//   - state_e       : transmitter FSM state encoding (2 bits)
//   - DEF_PRE_W     : default preamble length in bits
//   - DEF_PREAMBLE  : default preamble pattern, sent MSB first
// Optional feature macro: MOORE_SEQ_TX_PARITY_EN adds the PAR state.
// -----------------------------------------------------------------------------
package moore_seq_pkg;

   localparam int DEF_PRE_W = 3;
   localparam logic [DEF_PRE_W-1:0] DEF_PREAMBLE = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
`ifdef MOORE_SEQ_TX_PARITY_EN
      ST_DATA = 2'd2,
      ST_PAR  = 2'd3
`else
      ST_DATA = 2'd2
`endif
   } state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// -----------------------------------------------------------------------------
// seq_tx_shreg
// Load / shift-left register holding the word being serialised.
//   clk      in  : clock, rising edge
//   reset    in  : synchronous, active-high clear
//   i_load   in  : latch i_data (has priority over i_shift)
//   i_shift  in  : shift left by one, zero fill
//   i_data   in  : word to load [DATA_W]
//   o_msb    out : current MSB of the register
//   o_par    out : XOR of the word captured at load (only with
//                  MOORE_SEQ_TX_PARITY_EN defined)
// -----------------------------------------------------------------------------
module seq_tx_shreg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_msb
`ifdef MOORE_SEQ_TX_PARITY_EN
  ,output logic              o_par
`endif
);

   logic [DATA_W-1:0] r_sh;

   assign o_msb = r_sh[DATA_W-1];

   // Shift register: load a new word or move the next bit into the MSB.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh <= {DATA_W{1'b0}};
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= r_sh << 1;
      end else begin
         r_sh <= r_sh;
      end
   end

`ifdef MOORE_SEQ_TX_PARITY_EN
   // XOR of all data bits; appending it gives even parity over data + bit.
   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   logic r_par;

   assign o_par = r_par;

   // Parity is captured once at load, since the word itself is shifted away.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_par <= 1'b0;
      end else if (i_load) begin
         r_par <= even_par(i_data);
      end else begin
         r_par <= r_par;
      end
   end
`endif

endmodule

// File: rtl/moore_seq_tx.sv
// -----------------------------------------------------------------------------
// moore_seq_tx
// Serial framed transmitter: preamble, data word MSB first, optional even
// parity bit. The line idles high. All outputs are registered (Moore).
// Optional feature macro: MOORE_SEQ_TX_PARITY_EN (adds the parity bit).
//   clk       in  : clock, rising edge
//   reset     in  : synchronous, active-high; aborts any frame in progress
//   in_data   in  : word to send [DATA_W], sampled on accept
//   in_valid  in  : in_data valid
//   in_ready  out : transmitter can accept a word (IDLE and not in reset)
//   tx_bit    out : serial line, idle level 1
//   tx_en     out : tx_bit carries a frame bit
//   busy      out : frame in progress
//   done      out : one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module moore_seq_tx
   import moore_seq_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                PRE_W    = DEF_PRE_W,
   parameter logic [PRE_W-1:0]  PREAMBLE = DEF_PREAMBLE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_en,
   output logic              busy,
   output logic              done
);

   localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W - 1);
   localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

   // Preamble bit lookup; the counter may be wider than the preamble index.
   function automatic logic pre_bit(input logic [CNT_W-1:0] idx);
      logic b;
      b = 1'b1;
      for (int i = 0; i < PRE_W; i++) begin
         b = (idx == CNT_W'(i)) ? PREAMBLE[i] : b;
      end
      return b;
   endfunction

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tx_bit;
   logic             r_tx_en;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_shift;
   logic             w_msb;
`ifdef MOORE_SEQ_TX_PARITY_EN
   logic             w_par;
`endif

   assign in_ready = (r_state == ST_IDLE) && !reset;
   assign w_accept = in_valid && in_ready;

   // tx_bit is registered one cycle ahead, so the register shifts when its
   // MSB is moved into tx_bit: at the last preamble bit and every data bit
   // except the final one.
   assign w_shift  = ((r_state == ST_PRE)  && (r_cnt == CNT_ZERO)) ||
                     ((r_state == ST_DATA) && (r_cnt != CNT_ZERO));

   assign tx_bit = r_tx_bit;
   assign tx_en  = r_tx_en;
   assign busy   = r_busy;
   assign done   = r_done;

   seq_tx_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_accept),
      .i_shift (w_shift),
      .i_data  (in_data),
      .o_msb   (w_msb)
`ifdef MOORE_SEQ_TX_PARITY_EN
     ,.o_par   (w_par)
`endif
   );

   // Frame FSM: state, bit counter and registered line outputs for the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= CNT_ZERO;
         r_tx_bit <= 1'b1;
         r_tx_en  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_state  <= ST_PRE;
                  r_cnt    <= PRE_LAST;
                  r_tx_bit <= pre_bit(PRE_LAST);
                  r_tx_en  <= 1'b1;
                  r_busy   <= 1'b1;
               end else begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= CNT_ZERO;
                  r_tx_bit <= 1'b1;
                  r_tx_en  <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end

            ST_PRE: begin
               if (r_cnt == CNT_ZERO) begin
                  r_state  <= ST_DATA;
                  r_cnt    <= DAT_LAST;
                  r_tx_bit <= w_msb;
               end else begin
                  r_cnt    <= r_cnt - CNT_ONE;
                  r_tx_bit <= pre_bit(r_cnt - CNT_ONE);
               end
            end

            ST_DATA: begin
               if (r_cnt != CNT_ZERO) begin
                  r_cnt    <= r_cnt - CNT_ONE;
                  r_tx_bit <= w_msb;
               end else begin
`ifdef MOORE_SEQ_TX_PARITY_EN
                  r_state  <= ST_PAR;
                  r_cnt    <= CNT_ZERO;
                  r_tx_bit <= w_par;
`else
                  r_state  <= ST_IDLE;
                  r_cnt    <= CNT_ZERO;
                  r_tx_bit <= 1'b1;
                  r_tx_en  <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
`endif
               end
            end

`ifdef MOORE_SEQ_TX_PARITY_EN
            ST_PAR: begin
               r_state  <= ST_IDLE;
               r_cnt    <= CNT_ZERO;
               r_tx_bit <= 1'b1;
               r_tx_en  <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
            end
`endif

            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= CNT_ZERO;
               r_tx_bit <= 1'b1;
               r_tx_en  <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moore_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_tx
// Self-checking bench for moore_seq_tx. Each accepted word pushes its whole
// expected frame (preamble, data MSB first, parity when
// MOORE_SEQ_TX_PARITY_EN is defined) into a bit queue; a monitor on the
// falling edge pops one bit per active cycle and checks line, enables,
// ready and done against that queue.
// -----------------------------------------------------------------------------
module tb_moore_seq_tx;

   localparam int DATA_W = 8;
   localparam int PRE_W  = 3;
`ifdef MOORE_SEQ_TX_PARITY_EN
   localparam int FRAME_LEN = PRE_W + DATA_W + 1;
`else
   localparam int FRAME_LEN = PRE_W + DATA_W;
`endif

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              tx_bit;
   logic              tx_en;
   logic              busy;
   logic              done;

   bit   exp_q[$];
   int   n_checks;
   int   n_errors;
   int   cyc;
   bit   mon_on;
   bit   prev_active;
   int   drv_aborts;
   int   mon_aborts;

   moore_seq_tx #(
      .DATA_W (DATA_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_bit   (tx_bit),
      .tx_en    (tx_en),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to time accepts.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // Expected frame of a word, built straight from the framing rules.
   task automatic push_frame(input logic [DATA_W-1:0] d);
      logic [PRE_W-1:0] pre;
      pre = 3'b001;
      for (int i = PRE_W - 1; i >= 0; i--) exp_q.push_back(pre[i]);
      for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef MOORE_SEQ_TX_PARITY_EN
      exp_q.push_back(^d);
`endif
   endtask

   // Present a word until it is accepted; acc_cyc is the cycle count after the accepting edge.
   task automatic send(input logic [DATA_W-1:0] d, input bit keep_valid, output int acc_cyc);
      int  waited;
      bit  got;
      in_data  = d;
      in_valid = 1'b1;
      waited   = 0;
      got      = 1'b0;
      acc_cyc  = 0;
      while (!got && waited < 200) begin
         @(negedge clk);
         if (in_ready === 1'b1) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: word %h never accepted within %0d cycles", d, waited);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         push_frame(d);
         if (!keep_valid) in_valid = 1'b0;
      end
   endtask

   // Wait for the expected frames to drain, then let the done cycle pass.
   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d expected bits still pending", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every cycle against the scoreboard queue.
   always @(negedge clk) begin
      bit active;
      bit exp_bit;
      bit aborted;
      if (mon_on) begin
         active  = (exp_q.size() != 0);
         aborted = (drv_aborts != mon_aborts);
         chk("tx_en", tx_en, active);
         chk("busy", busy, active);
         chk("in_ready", in_ready, !active && !reset);
         if (active) begin
            exp_bit = exp_q.pop_front();
            chk("tx_bit", tx_bit, exp_bit);
         end else begin
            chk("idle_bit", tx_bit, 1'b1);
         end
         chk("done", done, prev_active && !active && !aborted);
         prev_active = active;
         mon_aborts  = drv_aborts;
      end
   end

   initial begin
      int k1;
      int k2;
      logic [DATA_W-1:0] d;
      int gap;
      bit keep;

      n_checks    = 0;
      n_errors    = 0;
      cyc         = 0;
      mon_on      = 1'b0;
      prev_active = 1'b0;
      drv_aborts  = 0;
      mon_aborts  = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;

      // Reset, then idle 10 cycles.
      repeat (3) @(posedge clk);
      #1;
      mon_on = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Directed frames: A5 and 07 (parity 0 and 1 when enabled).
      send(8'hA5, 1'b0, k1);
      drain();
      send(8'h07, 1'b0, k1);
      drain();

      // Back-to-back with in_valid held: exactly one idle bit between frames.
      send(8'h00, 1'b1, k1);
      send(8'hFF, 1'b0, k2);
      n_checks++;
      if (k2 - k1 != FRAME_LEN + 1) begin
         n_errors++;
         $display("FAIL b2b_spacing: got %0d cycles expected %0d", k2 - k1, FRAME_LEN + 1);
      end
      drain();

      // Reset during the 5th data bit of C3, then 3C must go out intact.
      send(8'hC3, 1'b0, k1);
      repeat (PRE_W + 4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      drv_aborts++;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(8'h3C, 1'b0, k1);
      drain();

      // Toggle in_valid with 55 while busy: must be ignored until ready.
      send(8'hAA, 1'b0, k1);
      for (int i = 0; i < 5; i++) begin
         in_data  = 8'h55;
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      send(8'h55, 1'b0, k1);
      drain();

      // Randomized words with random gaps and held-valid back-to-back.
      for (int i = 0; i < 40; i++) begin
         d    = DATA_W'($urandom);
         gap  = $urandom_range(0, 3);
         keep = (gap == 0) && ($urandom_range(0, 1) == 1);
         send(d, keep, k1);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
